// File: rtl/raymarch_pkg.sv
// Shared types for the shading-stage output path: pixel/word layouts and packer phases.
package raymarch_pkg;

  localparam int PIX_WIDTH   = 24;
  localparam int TDATA_WIDTH = 32;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // eof rides along with each word so frame_done can fire on the downstream accept.
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tuser;
    logic                   tlast;
    logic                   eof;
  } axis_word_t;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } pack_phase_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic two-entry skid buffer; upstream ready is registered and reflects space after this cycle.
module axis_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       push;
  logic       pop;
  T           skid_q;

  assign push      = in_valid && in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};

  // out_data is the head entry; skid_q only ever holds the second-oldest word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      in_ready <= 1'b0;
      out_data <= '0;
      skid_q   <= '0;
    end else begin
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != 2'd2);
      if (pop) begin
        if (cnt == 2'd2) begin
          out_data <= skid_q;
          if (push) skid_q <= in_data;
        end else if (push) begin
          out_data <= in_data;
        end
      end else if (push) begin
        if (cnt == 2'd0) out_data <= in_data;
        else             skid_q   <= in_data;
      end
    end
  end

endmodule

// File: rtl/shade_pixel_streamer.sv
// Shading-stage pixel sink to AXI4-Stream video with SOF/EOL markers.
// Define SHADE_RGB_PACK_EN to pack four 24-bit pixels into three 32-bit words.
//
// Packer phases (SHADE_RGB_PACK_EN only):
//   state | meaning
//   PH0   | p0 captured into carry, no word emitted
//   PH1   | emit W0 = {p1[7:0], p0}, carry p1[23:8]
//   PH2   | emit W1 = {p2[15:0], p1[23:8]}, carry p2[23:16]
//   PH3   | emit W2 = {p3, p2[23:16]}, group complete
module shade_pixel_streamer
  import raymarch_pkg::*;
#(
  parameter int X_RES       = 640,
  parameter int Y_RES       = 480,
  parameter int PIX_WIDTH   = 24,
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_WIDTH-1:0]   pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   frame_done
);

  localparam int XW = $clog2(X_RES);
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;

  if (PIX_WIDTH != 24 || TDATA_WIDTH != 32) begin : g_bad_width
    $error("shade_pixel_streamer supports only 24-bit pixels and 32-bit words");
  end

  logic [XW-1:0]          x_cnt;
  logic [YW-1:0]          y_cnt;
  logic                   x_last;
  logic                   y_last;
  logic                   accept;
  logic                   emit;
  logic [TDATA_WIDTH-1:0] word_data;
  logic                   word_user;
  logic                   word_last;
  axis_word_t             in_word;
  axis_word_t             out_word;

  assign x_last = (x_cnt == XW'(X_RES - 1));
  assign y_last = (y_cnt == YW'(Y_RES - 1));
  assign accept = pix_valid && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

`ifdef SHADE_RGB_PACK_EN
  if (X_RES % 4 != 0) begin : g_bad_xres
    $error("X_RES must be a multiple of 4 when RGB packing is enabled");
  end

  pack_phase_t phase;
  logic [23:0] carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH0;
      carry <= '0;
    end else if (accept) begin
      case (phase)
        PH0: begin carry <= pix_in;                   phase <= PH1; end
        PH1: begin carry <= {8'h00, pix_in[23:8]};    phase <= PH2; end
        PH2: begin carry <= {16'h0000, pix_in[23:16]}; phase <= PH3; end
        PH3: begin                                    phase <= PH0; end
        default: phase <= PH0;
      endcase
    end
  end

  // Groups are line-aligned, so a frame's first W0 is emitted at x=1, y=0.
  always_comb begin
    emit      = 1'b0;
    word_data = '0;
    word_user = 1'b0;
    word_last = 1'b0;
    case (phase)
      PH1: begin
        emit      = 1'b1;
        word_data = {pix_in[7:0], carry};
        word_user = (x_cnt == XW'(1)) && (y_cnt == '0);
      end
      PH2: begin
        emit      = 1'b1;
        word_data = {pix_in[15:0], carry[15:0]};
      end
      PH3: begin
        emit      = 1'b1;
        word_data = {pix_in, carry[7:0]};
        word_last = x_last;
      end
      default: emit = 1'b0;
    endcase
  end
`else
  assign emit      = 1'b1;
  assign word_data = {8'h00, pix_in};
  assign word_user = (x_cnt == '0) && (y_cnt == '0);
  assign word_last = x_last;
`endif

  always_comb begin
    in_word       = '0;
    in_word.tdata = word_data;
    in_word.tuser = word_user;
    in_word.tlast = word_last;
    in_word.eof   = word_last && y_last;
  end

  // PH0 pixels are accepted without pushing, so the buffer only sees emitting cycles.
  axis_skid_buffer #(
    .T(axis_word_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_word),
    .in_valid  (pix_valid && emit),
    .in_ready  (pix_ready),
    .out_data  (out_word),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign m_axis_tdata = out_word.tdata;
  assign m_axis_tuser = out_word.tuser;
  assign m_axis_tlast = out_word.tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= m_axis_tvalid && m_axis_tready && out_word.eof;
  end

endmodule

// File: tb/tb_shade_pixel_streamer.sv
// Self-checking bench for shade_pixel_streamer (unpacked by default, packed with SHADE_RGB_PACK_EN).
module tb_shade_pixel_streamer;

  localparam int XR   = 4;
  localparam int YR   = 2;
  localparam int NPIX = XR * YR;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } exp_t;

  typedef struct packed {
    logic [23:0] pix;
    logic        emit;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int popped = 0;
  int fd_cnt = 0;
  int stall_n = 0;
  int stall_acc = 0;
  int rdy_mode = 0;
  bit saw_low = 0;
  bit first_seen = 0;
  bit first_user = 0;
  bit fd_exp = 0;
  bit hold_v = 0;
  logic [33:0] hold_w = '0;
  logic [31:0] stall_data = '0;
  logic [31:0] stall_exp = '0;
  int t0, t1;

  exp_t sb[$];
  vec_t tab[NPIX];

  int mx = 0, my = 0, mph = 0;
  logic [23:0] grp[3];
  bit gsof = 0;

  shade_pixel_streamer #(
    .X_RES(XR),
    .Y_RES(YR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_in        (pix_in),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic vec_t mk(logic [23:0] p, logic em, logic [31:0] d, logic u, logic l, logic f);
    vec_t v;
    v.pix = p; v.emit = em; v.e.data = d; v.e.user = u; v.e.last = l; v.e.eof = f;
    return v;
  endfunction

  function automatic void model_reset();
    mx = 0; my = 0; mph = 0; gsof = 0;
  endfunction

  // Reference: expected word (if any) for the next accepted pixel, straight from the word layout.
  function automatic void model_step(input logic [23:0] p, output bit em, output exp_t w);
    w  = '0;
    em = 1'b1;
`ifdef SHADE_RGB_PACK_EN
    case (mph)
      0: begin em = 1'b0; grp[0] = p; gsof = (mx == 0 && my == 0); end
      1: begin w.data = {p[7:0], grp[0]}; w.user = gsof; grp[1] = p; end
      2: begin w.data = {p[15:0], grp[1][23:8]}; grp[2] = p; end
      default: begin
        w.data = {p, grp[2][23:16]};
        w.last = (mx == XR - 1);
        w.eof  = w.last && (my == YR - 1);
      end
    endcase
    mph = (mph + 1) % 4;
`else
    w.data = {8'h00, p};
    w.user = (mx == 0 && my == 0);
    w.last = (mx == XR - 1);
    w.eof  = w.last && (my == YR - 1);
`endif
    if (mx == XR - 1) begin
      mx = 0;
      my = (my == YR - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endfunction

  task automatic send(input logic [23:0] p, input bit use_tab, input vec_t v);
    int   n = 0;
    bit   em;
    exp_t w;
    pix_in    = p;
    pix_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ready && n < 200);
    if (!pix_ready) begin
      chk("accept_timeout", 64'(pix_ready), 64'(1));
    end else begin
      model_step(p, em, w);
      if (use_tab) begin
        em = v.emit;
        w  = v.e;
      end
      if (em) sb.push_back(w);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream ready patterns: 0 always, 1 random, 2 stall five cycles with word 3 at the head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin
          if (popped == 2 && stall_n < 5) begin
            m_axis_tready = 1'b0;
            stall_n++;
          end else begin
            m_axis_tready = 1'b1;
          end
        end
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pop, hold stability, frame_done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        fd_exp     = 1'b0;
        hold_v     = 1'b0;
        first_seen = 1'b0;
      end else begin
        chk("frame_done_timing", 64'(frame_done), 64'(fd_exp));
        if (frame_done) fd_cnt++;
        if (hold_v)
          chk("hold_stable", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
              64'({1'b1, hold_w}));
        fd_exp = 1'b0;
        if (rdy_mode == 2 && !m_axis_tready) begin
          if (!pix_ready) saw_low = 1'b1;
          if (pix_valid && pix_ready) stall_acc++;
          if (m_axis_tvalid) stall_data = m_axis_tdata;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          popped++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_user = m_axis_tuser;
          end
          if (sb.size() == 0) begin
            chk("unexpected_word", 64'(m_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("word", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                64'({e.data, e.user, e.last}));
            fd_exp = e.eof;
          end
        end
        hold_v = m_axis_tvalid && !m_axis_tready;
        hold_w = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SHADE_RGB_PACK_EN
    tab[0] = mk(24'hAABBCC, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    tab[1] = mk(24'h112233, 1'b1, 32'h33AABBCC, 1'b1, 1'b0, 1'b0);
    tab[2] = mk(24'h445566, 1'b1, 32'h55661122, 1'b0, 1'b0, 1'b0);
    tab[3] = mk(24'h778899, 1'b1, 32'h77889944, 1'b0, 1'b1, 1'b0);
    tab[4] = mk(24'h010203, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    tab[5] = mk(24'h040506, 1'b1, 32'h06010203, 1'b0, 1'b0, 1'b0);
    tab[6] = mk(24'h070809, 1'b1, 32'h08090405, 1'b0, 1'b0, 1'b0);
    tab[7] = mk(24'h0A0B0C, 1'b1, 32'h0A0B0C07, 1'b0, 1'b1, 1'b1);
    stall_exp = 32'h77889944;
`else
    for (int i = 0; i < NPIX; i++)
      tab[i] = mk(24'(i + 1), 1'b1, 32'(i + 1), i == 0, (i == 3) || (i == 7), i == 7);
    stall_exp = 32'h00000003;
`endif

    // Reset values and ready rising on the first edge after release.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", 64'(pix_ready), 64'(0));
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_tuser", 64'(m_axis_tuser), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 64'(pix_ready), 64'(0));
    @(negedge clk);
    chk("ready_after_edge", 64'(pix_ready), 64'(1));
    @(posedge clk);
    #1;

    // Table frame with tready held high.
    rdy_mode = 0;
    fd_cnt   = 0;
    for (int i = 0; i < NPIX; i++) send(tab[i].pix, 1'b1, tab[i]);
    drain();
    chk("t1_frame_done_count", 64'(fd_cnt), 64'(1));

    // Same frame, downstream stalls five cycles with word 3 at the head.
    stall_n = 0; popped = 0; fd_cnt = 0; saw_low = 0; stall_acc = 0; stall_data = '0;
    rdy_mode = 2;
    for (int i = 0; i < NPIX; i++) send(tab[i].pix, 1'b1, tab[i]);
    drain();
    rdy_mode = 0;
    chk("stall_held_word", 64'(stall_data), 64'(stall_exp));
    chk("stall_ready_fell", 64'(saw_low), 64'(1));
    chk("stall_accepts_le2", 64'(stall_acc <= 2), 64'(1));
    chk("stall_frame_done_count", 64'(fd_cnt), 64'(1));

    // Sustained throughput: one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < NPIX; i++) send(24'($urandom), 1'b0, '0);
    t1 = cyc;
    chk("throughput_cycles", 64'(t1 - t0), 64'(NPIX));
    drain();

    // Reset after three pixels of a frame; fresh frame must start clean.
    for (int i = 0; i < 3; i++) send(24'hF0F0F0 ^ 24'(i), 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("midrst_pix_ready", 64'(pix_ready), 64'(0));
    sb.delete();
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    fd_cnt = 0;
    for (int i = 0; i < NPIX; i++) send(24'h123400 + 24'(i * 17), 1'b0, '0);
    drain();
    chk("midrst_first_tuser", 64'(first_user), 64'(1));
    chk("midrst_frame_done_count", 64'(fd_cnt), 64'(1));

    // Two back-to-back frames with random downstream ready.
    fd_cnt   = 0;
    rdy_mode = 1;
    for (int i = 0; i < 2 * NPIX; i++) send(24'($urandom), 1'b0, '0);
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("random_frame_done_count", 64'(fd_cnt), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
